// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the call stack.
package stack_pkg;

  localparam int STACK_DW    = 10;
  localparam int STACK_DEPTH = 16;

  // Encoding matches the {push, pop} input pair.
  typedef enum logic [1:0] {
    NOP  = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    REPL = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: synchronous write, asynchronous read, no reset.
module stack_mem #(
  parameter  int DW    = 10,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Call stack with registered top-of-stack output and sticky error flags.
module call_stack
  import stack_pkg::*;
#(
  parameter  int DW    = STACK_DW,
  parameter  int DEPTH = STACK_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  logic [AW:0]   sp;
  logic [AW:0]   sp_next;
  logic [DW-1:0] dout_next;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          ovf_set;
  logic          udf_set;
  op_e           op;

  assign count   = sp;
  assign empty   = (sp == '0);
  assign full    = (sp == SP_FULL);
  // Entry just below the top, which becomes the new top after a pop.
  assign rd_addr = sp[AW-1:0] - AW'(2);

  stack_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Decode the requested operation into next pointer, next top word and error events.
  always_comb begin
    op        = decode_op(push, pop);
    wr_en     = 1'b0;
    wr_addr   = sp[AW-1:0];
    sp_next   = sp;
    dout_next = data_out;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (op == REPL && empty) begin
      op = PUSH;
    end
    case (op)
      PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en     = 1'b1;
          sp_next   = sp + SP_ONE;
          dout_next = data_in;
        end
      end
      POP: begin
        if (empty) begin
          udf_set = 1'b1;
        end else begin
          sp_next   = sp - SP_ONE;
          dout_next = (sp == SP_ONE) ? '0 : rd_data;
        end
      end
      REPL: begin
        wr_en     = 1'b1;
        wr_addr   = sp[AW-1:0] - AW'(1);
        dout_next = data_in;
      end
      default: begin
      end
    endcase
  end

  // Pointer, top-of-stack and sticky flag registers; a new error beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      data_out  <= dout_next;
      overflow  <= (overflow  & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | udf_set;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack (DW=10, DEPTH=16).
module tb_call_stack;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  // Packed observation: {count, empty, full, data_out, overflow, underflow}
  logic [18:0] obs;
  assign obs = {count, empty, full, data_out, overflow, underflow};

  int vectors;
  int miscompares;

  call_stack #(
    .DW    (10),
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .data_in   (data_in),
    .data_out  (data_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation for one rising edge, then return to idle 1 time unit later.
  task automatic do_op(input logic p, input logic q, input logic [9:0] d, input logic c);
    push    = p;
    pop     = q;
    data_in = d;
    clr_err = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  // Pulse reset away from the clock edge and release it after an edge.
  task automatic reset_dut();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      do_op(1'b1, 1'b0, 10'(i), 1'b0);
      vectors++;
      if (obs !== {5'(i), 1'b0, (i == 16), 10'(i), 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL fill_push_%0d: got %h expected %h", i, obs, {5'(i), 1'b0, (i == 16), 10'(i), 1'b0, 1'b0});
      end
    end
    do_op(1'b1, 1'b0, 10'h3FF, 1'b0);
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL overflow_push: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0});
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 16; k++) begin
      do_op(1'b0, 1'b1, 10'h000, 1'b0);
      vectors++;
      if (obs !== {5'(16 - k), (k == 16), 1'b0, 10'(16 - k), 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL drain_pop_%0d: got %h expected %h", k, obs, {5'(16 - k), (k == 16), 1'b0, 10'(16 - k), 1'b1, 1'b0});
      end
    end
    do_op(1'b0, 1'b1, 10'h000, 1'b0);
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL underflow_pop: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1});
    end
    do_op(1'b0, 1'b0, 10'h000, 1'b1);
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL clr_both_flags: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0});
    end
  endtask

  task automatic test_replace();
    do_op(1'b1, 1'b0, 10'h0AA, 1'b0);
    do_op(1'b1, 1'b1, 10'h155, 1'b0);
    vectors++;
    if (obs !== {5'd1, 1'b0, 1'b0, 10'h155, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL repl_single: got %h expected %h", obs, {5'd1, 1'b0, 1'b0, 10'h155, 1'b0, 1'b0});
    end
    do_op(1'b0, 1'b1, 10'h000, 1'b0);
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL repl_then_pop: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0});
    end
    for (int i = 1; i <= 16; i++) begin
      do_op(1'b1, 1'b0, 10'h100 + 10'(i), 1'b0);
    end
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h110, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL refill_full: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h110, 1'b0, 1'b0});
    end
    do_op(1'b1, 1'b1, 10'h3C3, 1'b0);
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h3C3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL repl_full: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h3C3, 1'b0, 1'b0});
    end
    do_op(1'b0, 1'b1, 10'h000, 1'b0);
    vectors++;
    if (obs !== {5'd15, 1'b0, 1'b0, 10'h10F, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL pop_after_repl_full: got %h expected %h", obs, {5'd15, 1'b0, 1'b0, 10'h10F, 1'b0, 1'b0});
    end
    do_op(1'b0, 1'b1, 10'h000, 1'b0);
    vectors++;
    if (obs !== {5'd14, 1'b0, 1'b0, 10'h10E, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL pop_back_to_back: got %h expected %h", obs, {5'd14, 1'b0, 1'b0, 10'h10E, 1'b0, 1'b0});
    end
  endtask

  task automatic test_empty_repl();
    reset_dut();
    do_op(1'b1, 1'b1, 10'h2F0, 1'b0);
    vectors++;
    if (obs !== {5'd1, 1'b0, 1'b0, 10'h2F0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL repl_empty: got %h expected %h", obs, {5'd1, 1'b0, 1'b0, 10'h2F0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_clr_err();
    reset_dut();
    for (int i = 1; i <= 16; i++) begin
      do_op(1'b1, 1'b0, 10'(i), 1'b0);
    end
    do_op(1'b1, 1'b0, 10'h200, 1'b0);
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ovf_set: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0});
    end
    do_op(1'b1, 1'b0, 10'h201, 1'b1);
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL set_beats_clr: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h010, 1'b1, 1'b0});
    end
    do_op(1'b0, 1'b0, 10'h000, 1'b1);
    vectors++;
    if (obs !== {5'd16, 1'b0, 1'b1, 10'h010, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL clr_alone: got %h expected %h", obs, {5'd16, 1'b0, 1'b1, 10'h010, 1'b0, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    do_op(1'b0, 1'b1, 10'h000, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      do_op(1'b1, 1'b0, 10'h030 + 10'(i), 1'b0);
    end
    vectors++;
    if (obs !== {5'd5, 1'b0, 1'b0, 10'h035, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_state: got %h expected %h", obs, {5'd5, 1'b0, 1'b0, 10'h035, 1'b0, 1'b1});
    end
    push    = 1'b1;
    data_in = 10'h077;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_immediate: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    push  = 1'b0;
    reset = 1'b1;
    #2;
    vectors++;
    if (obs !== {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL push_discarded: got %h expected %h", obs, {5'd0, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0});
    end
    do_op(1'b1, 1'b0, 10'h0C4, 1'b0);
    vectors++;
    if (obs !== {5'd1, 1'b0, 1'b0, 10'h0C4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL first_op_after_reset: got %h expected %h", obs, {5'd1, 1'b0, 1'b0, 10'h0C4, 1'b0, 1'b0});
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    clr_err     = 1'b0;
    data_in     = '0;
    test_reset();
    test_fill();
    test_drain();
    test_replace();
    test_empty_repl();
    test_clr_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
